// File: rtl/dmem_arb.sv
// dmem_arb: two-requester (core, DMA) arbiter for a single-port data RAM.
// One access in flight; winner is granted in ACCESS and completes after RESP.
// Ports: clk, rst (sync, active-high); core_*/dma_* request, grant, done and rdata;
// ram_we/ram_addr/ram_din to the RAM, ram_dout from it; busy when not IDLE.
// Optional macro DMEM_ARB_RR_EN: round-robin between simultaneous requests
// (default build: fixed priority, core wins).
module dmem_arb #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DWIDTH-1:0]     core_wdata,
  output logic                  core_gnt,
  output logic                  core_done,
  output logic [DWIDTH-1:0]     core_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DWIDTH-1:0]     dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_done,
  output logic [DWIDTH-1:0]     dma_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0]     ram_din,
  input  logic [DWIDTH-1:0]     ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t nxt;

  logic any_req;
  logic pick_dma;
  logic sel_dma;
  logic sel_we;
  logic win_we;

  assign any_req = core_req | dma_req;
  assign win_we  = pick_dma ? dma_we : core_we;

`ifdef DMEM_ARB_RR_EN
  // 1 = DMA was served last, so the core wins the next contention.
  logic last_dma;

  assign pick_dma = dma_req & (~core_req | ~last_dma);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dma <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_dma <= pick_dma;
    end
  end
`else
  assign pick_dma = dma_req & ~core_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = any_req ? ACCESS : IDLE;
      ACCESS:  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered: each is loaded one edge ahead of the
  // state in which it must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_gnt   <= 1'b0;
      dma_gnt    <= 1'b0;
      core_done  <= 1'b0;
      dma_done   <= 1'b0;
      core_rdata <= '0;
      dma_rdata  <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      busy       <= 1'b0;
      sel_dma    <= 1'b0;
      sel_we     <= 1'b0;
    end else begin
      core_gnt  <= 1'b0;
      dma_gnt   <= 1'b0;
      core_done <= 1'b0;
      dma_done  <= 1'b0;
      ram_we    <= 1'b0;
      busy      <= (nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (any_req) begin
            sel_dma  <= pick_dma;
            sel_we   <= win_we;
            ram_we   <= win_we;
            ram_addr <= pick_dma ? dma_addr : core_addr;
            // ram_din keeps its old value across reads
            if (win_we) begin
              ram_din <= pick_dma ? dma_wdata : core_wdata;
            end
            core_gnt <= ~pick_dma;
            dma_gnt  <= pick_dma;
          end
        end
        ACCESS: begin
        end
        RESP: begin
          if (!sel_we) begin
            if (sel_dma) begin
              dma_rdata <= ram_dout;
            end else begin
              core_rdata <= ram_dout;
            end
          end
          core_done <= ~sel_dma;
          dma_done  <= sel_dma;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed bench for dmem_arb with a small behavioural RAM.
// Expectations are hand-computed; both arbitration builds are covered.
module tb_dmem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [15:0] core_addr, core_wdata;
  logic        core_gnt, core_done;
  logic [15:0] core_rdata;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_done;
  logic [15:0] dma_rdata;
  logic        ram_we;
  logic [15:0] ram_addr, ram_din;
  logic [15:0] ram_dout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_core_rd;
  logic [15:0] exp_dma_rd;
  logic [15:0] last_wd;

  logic [15:0] mem [0:255] = '{default: 16'h0000};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_din;
    ram_dout <= mem[ram_addr[7:0]];
  end

  dmem_arb #(.DWIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_done(core_done),
    .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done),
    .dma_rdata(dma_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One complete access by a lone requester, starting in an IDLE cycle N.
  // The requester changes addr/wdata after gnt to prove they were latched.
  task automatic do_acc(input bit who, input bit we,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input string tag);
    if (who) begin
      dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
    end else begin
      core_req = 1; core_we = we; core_addr = a; core_wdata = d;
    end
    chk({tag, "_n_busy"}, busy, 0);
    step();
    core_req = 0; dma_req = 0;
    if (who) begin
      dma_addr = a ^ 16'h0030; dma_wdata = ~d;
    end else begin
      core_addr = a ^ 16'h0030; core_wdata = ~d;
    end
    chk({tag, "_gnt"}, {core_gnt, dma_gnt}, who ? 2'b01 : 2'b10);
    chk({tag, "_we1"}, ram_we, we);
    chk({tag, "_addr1"}, ram_addr, a);
    chk({tag, "_din"}, ram_din, we ? d : last_wd);
    chk({tag, "_busy1"}, busy, 1);
    step();
    chk({tag, "_we2"}, ram_we, 0);
    chk({tag, "_pulse2"}, {core_gnt, dma_gnt, core_done, dma_done}, 4'b0);
    chk({tag, "_addr2"}, ram_addr, a);
    step();
    if (we) last_wd = d;
    if (!we && who) exp_dma_rd = exp_rd;
    if (!we && !who) exp_core_rd = exp_rd;
    chk({tag, "_done"}, {core_done, dma_done}, who ? 2'b01 : 2'b10);
    chk({tag, "_busy3"}, busy, 0);
    chk({tag, "_crd"}, core_rdata, exp_core_rd);
    chk({tag, "_drd"}, dma_rdata, exp_dma_rd);
  endtask

  initial begin
    string order;
    int ng;
    int last_t;
    int t;
    rst = 1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    exp_core_rd = 0; exp_dma_rd = 0; last_wd = 0;
    step();
    step();
    chk("rst_outs",
        {core_gnt, core_done, dma_gnt, dma_done, ram_we, busy}, 6'b0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_rd", {core_rdata, dma_rdata}, 0);
    rst = 0;
    step();
    chk("idle_busy", busy, 0);

    do_acc(0, 1, 16'h0010, 16'hA5A5, 16'h0, "cw10");
    do_acc(1, 1, 16'h0020, 16'h5555, 16'h0, "dw20");
    do_acc(1, 1, 16'h0010, 16'h00A5, 16'h0, "dw10");
    do_acc(0, 0, 16'h0010, 16'h0000, 16'h00A5, "cr10");
    step();
    chk("crd_hold", core_rdata, 16'h00A5);
    do_acc(1, 1, 16'h0004, 16'h1234, 16'h0, "dw04");
    do_acc(1, 0, 16'h0004, 16'h0000, 16'h1234, "dr04");
    do_acc(1, 1, 16'h0004, 16'hBEEF, 16'h0, "dw04b");
    chk("drd_keep", dma_rdata, 16'h1234);
    chk("crd_keep", core_rdata, 16'h00A5);

    // Contention: DMA was served last, both request continuously.
    core_req = 1; core_we = 1; core_addr = 16'h0040; core_wdata = 16'h1111;
    dma_req = 1; dma_we = 1; dma_addr = 16'h0041; dma_wdata = 16'h2222;
    order = "";
    ng = 0;
    last_t = 0;
    t = 0;
    while (ng < 4 && t < 20) begin
      step();
      t++;
      if (core_gnt && dma_gnt) chk("both_gnt", 1, 0);
      if (core_gnt || dma_gnt) begin
        order = {order, core_gnt ? "C" : "D"};
        if (ng > 0) chk("gnt_gap", t - last_t, 3);
        last_t = t;
        ng++;
      end
    end
    core_req = 0; dma_req = 0;
    chk("gnt_count", ng, 4);
`ifdef DMEM_ARB_RR_EN
    chk("rr_order", (order == "CDCD") ? 1 : 0, 1);
`else
    chk("fix_order", (order == "CCCC") ? 1 : 0, 1);
`endif
    step();
    step();
    step();
    chk("cont_idle", busy, 0);

    // Reset while a core read sits in RESP.
    core_req = 1; core_we = 0; core_addr = 16'h0010;
    step();
    core_req = 0;
    chk("rr_gnt", core_gnt, 1);
    step();
    chk("rr_resp_busy", busy, 1);
    rst = 1;
    step();
    rst = 0;
    chk("ab_busy", busy, 0);
    chk("ab_done", {core_done, dma_done}, 2'b0);
    chk("ab_crd", core_rdata, 0);
    chk("ab_drd", dma_rdata, 0);
    chk("ab_ram", {ram_we, ram_addr, ram_din}, 0);
    step();
    chk("ab_nodone", {core_done, dma_done, busy}, 3'b0);

    // Pointer is back to DMA-last: core wins the first contention.
    core_req = 1; core_we = 0; core_addr = 16'h0010;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0004;
    step();
    core_req = 0; dma_req = 0;
    chk("post_rst_win", {core_gnt, dma_gnt}, 2'b10);
    step();
    step();
    chk("post_rst_done", {core_done, dma_done}, 2'b10);
    chk("post_rst_rd", core_rdata, 16'h00A5);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter DWIDTH, default 16, width of data words on all ports.
REQ-002 Parameter ADDR_WIDTH, default 16, width of all address ports.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-006 core_req, core_we  input  1 each  core access request; write when core_we=1.
REQ-007 core_addr  input  ADDR_WIDTH  core address; core_wdata  input  DWIDTH  core write data.
REQ-008 core_gnt  output  1  one-cycle pulse: core request accepted.
REQ-009 core_done  output  1  one-cycle pulse: core access complete; core_rdata  output  DWIDTH  read result.
REQ-010 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata: same directions, widths and meaning as REQ-006..009, for the DMA/loader requester.
REQ-011 ram_we  output  1; ram_addr  output  ADDR_WIDTH; ram_din  output  DWIDTH: drive data RAM.
REQ-012 ram_dout  input  DWIDTH  data RAM read data, valid one clk after ram_addr is presented with ram_we=0.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, ACCESS, RESP; single outstanding access; all outputs registered.
REQ-015 IDLE: if any req is high, latch winner's we/addr/wdata and winner ID, go to ACCESS; otherwise stay in IDLE.
REQ-016 ACCESS: drive ram_addr/ram_din from the latched values, ram_we = latched we, pulse winner's gnt, go to RESP.
REQ-017 RESP: ram_we=0; for a read, capture ram_dout into the winner's rdata register at end of cycle; go to IDLE.
REQ-018 The winner's done SHALL pulse for one cycle in the cycle after RESP, for both reads and writes.
REQ-019 Latency: req sampled in IDLE cycle N -> gnt in N+1 -> done (and rdata, for reads) in N+3.
REQ-020 Arbitration in the IDLE cycle that coincides with a done pulse SHALL be allowed, giving one access per 3 cycles back-to-back.
REQ-021 Requesters SHALL hold req/we/addr/wdata stable until gnt; the block SHALL ignore changes after latching.
REQ-022 ram_we SHALL be high for exactly one cycle per write and never for reads.
REQ-023 rdata of a requester SHALL hold its last read value until that requester's next read completes; writes do not modify it.
REQ-024 Never pulse gnt or done to the non-winning requester; gnt and done never both high for the same requester in one cycle.
REQ-025 The address SHALL pass through unmodified (no wrap or offset); ram_din is don't-care during reads and SHALL hold its last value.

Reset
REQ-026 rst SHALL force IDLE and clear ram_we, ram_addr, ram_din, all gnt/done pulses, both rdata registers, and busy to 0.
REQ-027 rst during ACCESS or RESP SHALL abort the access; no done pulse SHALL follow.
REQ-028 Round-robin pointer resets to "DMA last served", so the core wins the first contention.

Configuration
REQ-029 Macro DMEM_ARB_RR_EN: when defined, simultaneous requests alternate and the requester not served last wins.
REQ-030 Without DMEM_ARB_RR_EN, the core always wins simultaneous requests (fixed priority) and the pointer logic is absent.
REQ-031 A lone requester SHALL win immediately in both modes.

Verification
REQ-032 Core write addr 0x0010 data 0xA5A5 -> ram_we=1 one cycle with ram_addr=0x0010, ram_din=0xA5A5; core_done 3 cycles after req sampled.
REQ-033 Core read addr 0x0010 with RAM returning 0x00A5 -> core_gnt at N+1, core_done at N+3, core_rdata=0x00A5 held afterwards.
REQ-034 core_req and dma_req high together for 4 accesses, RR enabled -> grant order core, dma, core, dma; RR disabled -> core serviced 4 times before dma.
REQ-035 DMA read addr 0x0004 returning 0x1234, then DMA write -> dma_rdata stays 0x1234 after the write; core_rdata unchanged.
REQ-036 rst asserted in RESP of a core read -> next cycle IDLE, busy=0, no core_done, core_rdata=0.
REQ-037 Core changes core_addr 0x0010->0x0020 after gnt -> RAM still accessed at 0x0010.
